const_mul_add_seq: RTL and testbench
====================================

# const_mul_add_seq

Sequential constant multiply-add: reconstructs `value = quotient_i * VALUE_MULTIPLIER + remainder_i` one radix slice per cycle, LSB first, with a precomputed lookup table. It is the inverse of the team's constant-divider blocks and uses the same `valid_i`/`flush_i`/`valid_o`/`valid_next_o` handshake. It sits beside the divider in fixed-radix conversion paths, for example decimal-to-binary reassembly and the divide/reconstruct check loop.

## Interface
- `VALUE_MULTIPLIER`, 10: constant D, ≥2.
- `WIDTH_INPUT`, 16: operand and result width W.
- `WIDTH_RADIX`, 4: slice width R.
- `WIDTH_CARRY`, `$clog2(VALUE_MULTIPLIER)`: carry width C. Holds carries 0..D-1.
- `NUM_SLICE`, `ceil(WIDTH_INPUT/WIDTH_RADIX)`: slice count N.
- `clk_i` input 1: single clock. All state changes on its rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `flush_i` input 1: abort the operation in flight.
- `valid_i` input 1: operands present this cycle.
- `quotient_i` input W: multiplicand.
- `remainder_i` input W: addend. Legal range 0..D-1.
- `valid_o` output 1: result valid, 1-cycle pulse.
- `valid_next_o` output 1: `valid_o` asserts next cycle.
- `value_o` output W: result mod 2^W.
- `overflow_o` output 1: the true result is ≥ 2^W.
- `error_o` output 1: `remainder_i` ≥ D at accept.

## Operation
- **Lookup table**: 2^(R+C) entries, indexed by `{carry, digit}`.
  - Each entry is `{carry_out[C], digit_out[R]}`, where t = digit*D + carry, digit_out = t mod 2^R, carry_out = t >> R.
  - Entries with carry ≥ D are don't-care and are filled with 0.
- **FSM**: IDLE, WORKING, DONE.
- **IDLE**: `valid_i`=1 accepts the operands.
  - `quotient_i` is split into N slices; bits above W are zero-padded.
  - Carry initialises to `remainder_i[C-1:0]`. If `remainder_i` ≥ D, carry initialises to 0 and `error_o` is latched to 1.
  - Slice index is set to 0 and the FSM goes to WORKING.
- **WORKING**: one slice per cycle, always ascending.
  - Result slice[idx] ← digit_out; carry ← carry_out.
  - When idx == N-1, `valid_next_o`=1 and the FSM goes to DONE; otherwise idx increments.
  - All N slices are always processed; there is no early termination.
- **DONE**: `valid_o`=1 for exactly this cycle; the FSM returns to IDLE.
  - `valid_i` in DONE is accepted exactly as in IDLE, giving a back-to-back operation.
- **Overflow**: `overflow_o` is 1 if the final carry ≠ 0, or if any result bit at position ≥ W is 1 (partial top slice).
- **Held outputs**: `value_o`, `overflow_o` and `error_o` hold their values from DONE until the next accept. At the next accept, `overflow_o` and `error_o` are updated for the new operation.
- **WORKING ignores `valid_i`**: there is no queueing and no back-pressure. Upstream must use `valid_next_o`/`valid_o`.
- **Flush**: `flush_i`=1 forces `state_n`=IDLE in any state and overrides `valid_i`.
  - A flush in WORKING suppresses that operation's `valid_next_o`/`valid_o` from the next cycle on.
  - `valid_next_o` may already be high in the cycle flush is asserted.
  - `value_o` is undefined until the next completion.

## Timing
- **Reset**: state IDLE. `valid_o`, `valid_next_o`, `value_o`, `overflow_o` and `error_o` are all 0. Internal slice registers and carry are 0.
- **Latency**: accept edge at cycle 0 → WORKING cycles 1..N → `valid_next_o` in cycle N → `valid_o` in cycle N+1. Fixed at N+1 cycles regardless of operands.
- **Throughput**: one result per N+1 cycles with back-to-back accept in DONE.
- **Glitch-free outputs**: `valid_o` is a pure function of state. `valid_next_o` is a function of state and idx.
- **Reset mid-operation**: the asynchronous assertion immediately returns everything to reset values. No pulse is emitted after release.

## Test plan
Defaults: D=10, W=16, R=4, C=4, N=4.
1. `quotient_i`=1234, `remainder_i`=7, `valid_i` at cycle 0 → `valid_next_o` at cycle 4, `valid_o` at cycle 5, `value_o`=12347, `overflow_o`=0, `error_o`=0. Output is held afterwards.
2. Overflow boundary:
   - q=6553, r=5 → `value_o`=65535, `overflow_o`=0.
   - q=6553, r=6 → `value_o`=0, `overflow_o`=1.
   - q=65535, r=0 → `value_o`=655350 mod 65536 = 65526, `overflow_o`=1.
3. q=5, r=10 → `error_o`=1, `value_o`=50, same latency. A following q=5, r=9 → `error_o`=0, `value_o`=59.
4. Pulse `valid_i` with q=1, r=1 during WORKING of operation q=100, r=3 → only 1003 is produced. Then accept q=2, r=0 in the DONE cycle → `value_o`=20 exactly 5 cycles after that DONE cycle.
5. Flush at cycle 2 of q=777, r=1 → `valid_o` never asserts. A new operation q=9, r=9 → 99 with normal latency.
6. Deassert `rst_ni` at cycle 3 of an operation → all outputs go to 0 asynchronously. No `valid_o` after release. The next operation is correct.
7. Sweep q=0 and q=65535 for r=0..9 → results match the reference model, including `overflow_o`.

Source files
------------

// File: rtl/const_mul_add_seq.sv
// Sequential constant multiply-add: value = quotient_i * VALUE_MULTIPLIER + remainder_i,
// reconstructed one radix slice per cycle, LSB first, through a {carry, digit} lookup table.
module const_mul_add_seq #(
    parameter int VALUE_MULTIPLIER = 10,
    parameter int WIDTH_INPUT      = 16,
    parameter int WIDTH_RADIX      = 4,
    parameter int WIDTH_CARRY      = $clog2(VALUE_MULTIPLIER),
    parameter int NUM_SLICE        = (WIDTH_INPUT + WIDTH_RADIX - 1) / WIDTH_RADIX
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [WIDTH_INPUT-1:0] quotient_i,
    input  logic [WIDTH_INPUT-1:0] remainder_i,
    output logic                   valid_o,
    output logic                   valid_next_o,
    output logic [WIDTH_INPUT-1:0] value_o,
    output logic                   overflow_o,
    output logic                   error_o
);
    // state   | meaning
    // IDLE    | waiting for valid_i
    // WORKING | one slice per cycle, idx_q ascending 0..N-1
    // DONE    | result valid for one cycle; may accept the next operation
    localparam int D        = VALUE_MULTIPLIER;
    localparam int W        = WIDTH_INPUT;
    localparam int R        = WIDTH_RADIX;
    localparam int C        = WIDTH_CARRY;
    localparam int N        = NUM_SLICE;
    localparam int NR       = N * R;
    localparam int IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam int TOPB     = W - (N - 1) * R;
    localparam int LUT_SIZE = 2 ** (R + C);

    typedef enum logic [1:0] {IDLE, WORKING, DONE} state_t;

    function automatic logic [C+R-1:0] lut_entry(input int idx);
        int digit;
        int carry;
        int t;
        digit = idx % (2 ** R);
        carry = idx / (2 ** R);
        if (carry >= D) return '0;
        t = digit * D + carry;
        return {C'(t >> R), R'(t % (2 ** R))};
    endfunction

    logic [C+R-1:0] lut [LUT_SIZE];
    for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
        assign lut[gi] = lut_entry(gi);
    end

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [C-1:0]    carry_q, carry_d;
    logic [NR-1:0]   quot_q, quot_d;
    logic [NR-1:0]   res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;

    logic [R-1:0]    digit_in;
    logic [C+R-1:0]  lut_out;
    logic [R-1:0]    digit_out;
    logic [C-1:0]    carry_out;
    logic            last_slice;

    assign digit_in   = quot_q[int'(idx_q) * R +: R];
    assign lut_out    = lut[{carry_q, digit_in}];
    assign digit_out  = lut_out[R-1:0];
    assign carry_out  = lut_out[C+R-1:R];
    assign last_slice = (idx_q == IDXW'(N - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        quot_d  = quot_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (valid_i) begin
                        quot_d         = '0;
                        quot_d[W-1:0]  = quotient_i;
                        // Out-of-range addend is flagged and treated as zero.
                        if (remainder_i >= W'(D)) begin
                            carry_d = '0;
                            err_d   = 1'b1;
                        end else begin
                            carry_d = remainder_i[C-1:0];
                            err_d   = 1'b0;
                        end
                        ovf_d   = 1'b0;
                        idx_d   = '0;
                        state_d = WORKING;
                    end
                end
                WORKING: begin
                    res_d[int'(idx_q) * R +: R] = digit_out;
                    carry_d = carry_out;
                    if (last_slice) begin
                        state_d = DONE;
                        ovf_d   = (carry_out != '0) || ((digit_out >> TOPB) != '0);
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= '0;
            quot_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            quot_q  <= quot_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign valid_o      = (state_q == DONE);
    assign valid_next_o = (state_q == WORKING) && last_slice;
    assign value_o      = res_q[W-1:0];
    assign overflow_o   = ovf_q;
    assign error_o      = err_q;

endmodule

// File: tb/tb_const_mul_add_seq.sv
// Self-checking bench for const_mul_add_seq (D=10, W=16, R=4): directed cases plus
// random operands against an arithmetic reference model.
module tb_const_mul_add_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] quotient_i = '0;
    logic [15:0] remainder_i = '0;
    logic        valid_o;
    logic        valid_next_o;
    logic [15:0] value_o;
    logic        overflow_o;
    logic        error_o;

    int n_cmp = 0;
    int n_err = 0;

    const_mul_add_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .quotient_i   (quotient_i),
        .remainder_i  (remainder_i),
        .valid_o      (valid_o),
        .valid_next_o (valid_next_o),
        .value_o      (value_o),
        .overflow_o   (overflow_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int unsigned q, input int unsigned r,
                                  output logic [15:0] v, output logic ov, output logic er);
        longint unsigned full;
        er   = (r >= 10);
        full = longint'(q) * 10 + (er ? 0 : r);
        v    = full[15:0];
        ov   = (full >= 65536);
    endfunction

    // Caller is at a negedge; operands are accepted on the following posedge.
    task automatic issue(input int unsigned q, input int unsigned r);
        valid_i     = 1'b1;
        quotient_i  = q[15:0];
        remainder_i = r[15:0];
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Caller is at the negedge of cycle 'start' counted from the accept edge.
    task automatic await_result(input int unsigned q, input int unsigned r,
                                input int start, input string tag);
        int lat = start;
        int nxt = -1;
        logic [15:0] ev;
        logic eo, ee;
        while (!valid_o && lat < 12) begin
            if (valid_next_o && nxt < 0) nxt = lat;
            @(negedge clk_i);
            lat++;
        end
        model(q, r, ev, eo, ee);
        chk({tag, " latency"}, lat, 5);
        chk({tag, " next_lat"}, nxt, 4);
        chk({tag, " value"}, value_o, ev);
        chk({tag, " overflow"}, overflow_o, eo);
        chk({tag, " error"}, error_o, ee);
    endtask

    task automatic run_op(input int unsigned q, input int unsigned r, input string tag);
        @(negedge clk_i);
        issue(q, r);
        await_result(q, r, 1, tag);
    endtask

    task automatic count_valid(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (valid_o) hits++;
        end
    endtask

    initial begin
        int hits;
        int unsigned q, r;
        #1;
        chk("rst valid", valid_o, 0);
        chk("rst next", valid_next_o, 0);
        chk("rst value", value_o, 0);
        chk("rst ovf", overflow_o, 0);
        chk("rst err", error_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(1234, 7, "t1");
        repeat (3) @(negedge clk_i);
        chk("t1 hold value", value_o, 12347);
        chk("t1 hold valid", valid_o, 0);

        run_op(6553, 5, "t2a");
        run_op(6553, 6, "t2b");
        run_op(65535, 0, "t2c");

        run_op(5, 10, "t3a");
        run_op(5, 9, "t3b");

        // valid_i during WORKING is ignored; back-to-back accept in DONE
        @(negedge clk_i);
        issue(100, 3);
        @(negedge clk_i);
        valid_i = 1'b1; quotient_i = 16'd1; remainder_i = 16'd1;
        @(negedge clk_i);
        valid_i = 1'b0;
        await_result(100, 3, 3, "t4a");
        issue(2, 0);
        await_result(2, 0, 1, "t4b");

        // flush in cycle 2
        @(negedge clk_i);
        issue(777, 1);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        count_valid(8, hits);
        chk("t5 no valid", hits, 0);
        run_op(9, 9, "t5");

        // async reset in cycle 3 of an erroring operation
        @(negedge clk_i);
        issue(300, 12);
        @(negedge clk_i);
        @(posedge clk_i);
        #2;
        chk("t6 pre err", error_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("t6 rst valid", valid_o, 0);
        chk("t6 rst next", valid_next_o, 0);
        chk("t6 rst value", value_o, 0);
        chk("t6 rst ovf", overflow_o, 0);
        chk("t6 rst err", error_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        count_valid(8, hits);
        chk("t6 no valid", hits, 0);
        run_op(4321, 8, "t6");

        for (int i = 0; i < 10; i++) begin
            run_op(0, i, "t7 q0");
            run_op(65535, i, "t7 qmax");
        end

        for (int i = 0; i < 25; i++) begin
            q = $urandom_range(0, 65535);
            r = $urandom_range(0, 12);
            run_op(q, r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
